// File: rtl/mem_requester_if.sv
// Request/response port and TX/RX byte-FIFO link of the host-side memory requester.
// master: the requester itself; slave: the host and FIFO side facing it.
interface mem_requester_if #(
  parameter int unsigned FIFO_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [FIFO_WIDTH-1:0] req_addr;
  logic [FIFO_WIDTH-1:0] req_data;
  logic                  tx_fifo_full;
  logic                  tx_fifo_wr_en;
  logic [FIFO_WIDTH-1:0] dout;
  logic                  rx_fifo_empty;
  logic                  rx_fifo_rd_en;
  logic [FIFO_WIDTH-1:0] din;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [FIFO_WIDTH-1:0] resp_data;
  logic                  resp_err;

  modport master (
    input  req_valid, req_write, req_addr, req_data,
    input  tx_fifo_full, rx_fifo_empty, din, resp_ready,
    output req_ready, tx_fifo_wr_en, dout, rx_fifo_rd_en,
    output resp_valid, resp_data, resp_err
  );

  modport slave (
    output req_valid, req_write, req_addr, req_data,
    output tx_fifo_full, rx_fifo_empty, din, resp_ready,
    input  req_ready, tx_fifo_wr_en, dout, rx_fifo_rd_en,
    input  resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mem_requester.sv
// Host-side initiator for the byte-serial memory command protocol.
// Serializes one read/write request at a time into the TX byte FIFO
// (write: 49, addr, data; read: 48, addr) and collects the one-byte read
// echo from the RX byte FIFO.
// Optional feature: define MEM_REQ_TIMEOUT_EN to abort a read after
// TIMEOUT_CYCLES cycles in WAIT_RESP (resp_err=1, resp_data=all ones).
module mem_requester #(
  parameter int unsigned FIFO_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_requester_if.master        bus,
  output logic [5:0]             state_leds
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND_CMD  = 3'd1,
    S_SEND_ADDR = 3'd2,
    S_SEND_DATA = 3'd3,
    S_WAIT_RESP = 3'd4,
    S_CAPTURE   = 3'd5,
    S_RESP      = 3'd6
  } state_t;

  localparam logic [FIFO_WIDTH-1:0] CMD_WRITE = FIFO_WIDTH'(49);
  localparam logic [FIFO_WIDTH-1:0] CMD_READ  = FIFO_WIDTH'(48);

  state_t                state;
  logic                  lat_write;
  logic [FIFO_WIDTH-1:0] lat_addr;
  logic [FIFO_WIDTH-1:0] lat_data;
  logic [FIFO_WIDTH-1:0] resp_data_q;
  logic                  resp_err_q;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Sequencer: request latch, byte serialization, response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_data    <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_data  <= bus.req_data;
            state     <= S_SEND_CMD;
          end
        end
        S_SEND_CMD: begin
          if (!bus.tx_fifo_full) state <= S_SEND_ADDR;
        end
        S_SEND_ADDR: begin
          if (!bus.tx_fifo_full) begin
            state <= lat_write ? S_SEND_DATA : S_WAIT_RESP;
`ifdef MEM_REQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        S_SEND_DATA: begin
          if (!bus.tx_fifo_full) state <= S_IDLE;
        end
        S_WAIT_RESP: begin
          // A pop takes priority over an expiry in the same cycle
          if (!bus.rx_fifo_empty) begin
            state <= S_CAPTURE;
          end
`ifdef MEM_REQ_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            resp_data_q <= '1;
            resp_err_q  <= 1'b1;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_CAPTURE: begin
          resp_data_q <= bus.din;
          resp_err_q  <= 1'b0;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO strobes are gated by the live full/empty flags so a byte moves in
  // the same cycle the state is entered
  always_comb begin
    bus.tx_fifo_wr_en = 1'b0;
    bus.rx_fifo_rd_en = 1'b0;
    bus.dout          = '0;
    bus.resp_valid    = 1'b0;
    state_leds        = 6'b000000;
    case (state)
      S_IDLE:      state_leds = 6'b000000;
      S_SEND_CMD: begin
        state_leds        = 6'b000001;
        bus.tx_fifo_wr_en = ~bus.tx_fifo_full;
        bus.dout          = lat_write ? CMD_WRITE : CMD_READ;
      end
      S_SEND_ADDR: begin
        state_leds        = 6'b000010;
        bus.tx_fifo_wr_en = ~bus.tx_fifo_full;
        bus.dout          = lat_addr;
      end
      S_SEND_DATA: begin
        state_leds        = 6'b000100;
        bus.tx_fifo_wr_en = ~bus.tx_fifo_full;
        bus.dout          = lat_data;
      end
      S_WAIT_RESP: begin
        state_leds        = 6'b001000;
        bus.rx_fifo_rd_en = ~bus.rx_fifo_empty;
      end
      S_CAPTURE:   state_leds = 6'b010000;
      S_RESP: begin
        state_leds     = 6'b100000;
        bus.resp_valid = 1'b1;
      end
      default:     state_leds = 6'b111111;
    endcase
  end

  assign bus.req_ready = (state == S_IDLE) && !rst;
  assign bus.resp_data = resp_data_q;
`ifdef MEM_REQ_TIMEOUT_EN
  assign bus.resp_err  = resp_err_q;
`else
  assign bus.resp_err  = 1'b0;
`endif

endmodule

// File: doc/mem_requester.md
# mem_requester

Host-side initiator for the byte-serial memory command protocol: accepts single read/write requests on a valid/ready port, serializes them as command packets into a TX byte FIFO, and for reads collects the one-byte echo from an RX byte FIFO. It sits opposite the memory controller on the same UART/FIFO link, driving that controller's RX FIFO and draining its TX FIFO. Only one request is outstanding at a time.

## Interface
- FIFO_WIDTH, 8, byte width of FIFO data, address and data fields
- TIMEOUT_CYCLES, 1024, WAIT_RESP cycles before a read is aborted; used only with MEM_REQ_TIMEOUT_EN
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  reset, asynchronous and active-high
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE
- req_write  input  1  1 = write, 0 = read
- req_addr  input  FIFO_WIDTH  memory address
- req_data  input  FIFO_WIDTH  write data; ignored for reads
- tx_fifo_full  input  1  TX FIFO cannot accept a byte
- tx_fifo_wr_en  output  1  push dout this cycle
- dout  output  FIFO_WIDTH  byte to TX FIFO
- rx_fifo_empty  input  1  RX FIFO has no byte
- rx_fifo_rd_en  output  1  pop RX FIFO
- din  input  FIFO_WIDTH  RX FIFO read data, valid the cycle after a successful pop
- resp_valid  output  1  read response held
- resp_ready  input  1  consumer accepts response
- resp_data  output  FIFO_WIDTH  read data
- resp_err  output  1  timeout flag, valid with resp_valid
- state_leds  output  6  state indicator

## Operation
- Packet format: write = 8'd49, addr, data; read = 8'd48, addr. Read response = one data byte.
- States and state_leds: IDLE 000000, SEND_CMD 000001, SEND_ADDR 000010, SEND_DATA 000100, WAIT_RESP 001000, CAPTURE 010000, RESP 100000. Undefined encodings -> IDLE, leds 111111.
- IDLE: req_ready=1. On req_valid, latch req_write/req_addr/req_data and go to SEND_CMD. Latched fields are frozen until the next IDLE.
- SEND_CMD/SEND_ADDR/SEND_DATA: tx_fifo_wr_en = ~tx_fifo_full. dout = cmd byte / addr / data. Advance only when the byte is pushed; if full, stall in the same state with wr_en=0.
- After SEND_ADDR: write -> SEND_DATA; read -> WAIT_RESP. After SEND_DATA -> IDLE.
- WAIT_RESP: rx_fifo_rd_en = ~rx_fifo_empty. On a pop, go to CAPTURE.
- CAPTURE: register din into resp_data, resp_err=0, go to RESP.
- RESP: resp_valid=1, and the data is held stable. On resp_ready, go to IDLE.
- rx_fifo_rd_en is 0 in every state except WAIT_RESP. Stray RX bytes stay in the FIFO and are not discarded.
- Reset values: req_ready=0 during reset, then 1 in IDLE; tx_fifo_wr_en=0, rx_fifo_rd_en=0, resp_valid=0, resp_err=0, dout=0, resp_data=0, state_leds=000000.
- Reset mid-packet abandons the packet (partial bytes remain in the TX FIFO) and returns to IDLE.

## Timing
- Request accepted at edge of cycle N. Bytes are pushed in N+1, N+2 (,N+3) when the FIFO is never full; each full cycle adds one cycle.
- Write: req_ready is high again at N+4.
- Read with response already queued: rd_en at N+3, CAPTURE at N+4, resp_valid from N+5.
- Response-to-IDLE: resp_valid and resp_ready in the same cycle -> IDLE next cycle. Minimum read turnaround is 6 cycles.
- resp_valid never asserts for writes.

## Configuration
- MEM_REQ_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_RESP and increments each WAIT_RESP cycle without a pop.
  - On reaching TIMEOUT_CYCLES with no pop, go directly to RESP with resp_err=1 and resp_data=8'hFF.
  - If a pop and expiry occur in the same cycle, the pop wins.
- MEM_REQ_TIMEOUT_EN undefined:
  - No counter is built; WAIT_RESP waits indefinitely.
  - resp_err is tied to 0.

## Test plan
- Write addr 8'h12 data 8'hA5, FIFO never full -> TX bytes 49, 8'h12, 8'hA5 on consecutive cycles; req_ready back after 4 cycles; no resp_valid.
- Read addr 8'h34; bench queues 8'h5C in RX -> TX bytes 48, 8'h34; resp_valid with resp_data=8'h5C, resp_err=0; one pop only.
- Write with tx_fifo_full asserted for 3 cycles during SEND_ADDR -> no wr_en while full, address byte pushed exactly once, then data byte; total 7 cycles.
- Read with resp_ready held low for 5 cycles -> resp_valid and resp_data stable throughout; IDLE the cycle after resp_ready rises.
- MEM_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, RX never filled -> resp_valid with resp_err=1 and resp_data=8'hFF after 16 WAIT_RESP cycles. Without the macro, still waiting after 100 cycles.
- Assert rst in SEND_ADDR of a write -> all outputs at reset values immediately (async); after release, a new read completes normally.
